// File: rtl/trace_drain.sv
// trace_drain: buffers trace records in a FIFO and serialises each as OUT_WIDTH-bit stream beats.
// Define TRACE_DRAIN_HEADER_EN to prefix every packet with a {sequence, drop count} header beat.
module trace_drain #(
    parameter int REC_WIDTH = 128,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_valid_i,
    input  logic [REC_WIDTH-1:0]       trace_record_i,
    output logic                       out_valid_o,
    output logic [OUT_WIDTH-1:0]       out_data_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_count_o
);
    localparam int N  = REC_WIDTH / OUT_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
`ifdef TRACE_DRAIN_HEADER_EN
    localparam logic [1:0] HEADER = 2'd2;
    localparam logic [1:0] FIRST  = HEADER;
`else
    localparam logic [1:0] FIRST  = SEND;
`endif
    logic [1:0]           state;
    logic [IW-1:0]        idx;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [REC_WIDTH-1:0] mem [DEPTH];
    logic                 fire;
    logic                 pop;
    logic                 push;
    logic [AW:0]          level_nxt;
    logic [15:0]          drop_nxt;
    logic [OUT_WIDTH-1:0] beat;
    assign fire      = out_valid_o && out_ready_i;
    assign pop       = fire && state == SEND && idx == IW'(N - 1);
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push      = trace_valid_i && (fifo_level_o < (AW + 1)'(DEPTH) || pop);
    assign level_nxt = fifo_level_o + (AW + 1)'(push) - (AW + 1)'(pop);
    assign drop_nxt  = trace_valid_i && !push && drop_count_o != 16'hFFFF ? drop_count_o + 16'd1 : drop_count_o;
    assign beat      = mem[rd_ptr][int'(idx) * OUT_WIDTH +: OUT_WIDTH];
    assign out_valid_o = state != IDLE;
    assign out_last_o  = state == SEND && idx == IW'(N - 1);
`ifdef TRACE_DRAIN_HEADER_EN
    logic [15:0] seq;
    logic [15:0] hdr_drop;
    assign out_data_o = state == SEND ? beat : state == HEADER ? OUT_WIDTH'({seq, hdr_drop}) : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq      <= '0;
            hdr_drop <= '0;
        end else begin
            if (pop) seq <= seq + 16'd1;
            if ((state == IDLE && fifo_level_o != '0) || (pop && level_nxt != '0)) hdr_drop <= drop_nxt;
        end
    end
`else
    assign out_data_o = state == SEND ? beat : '0;
`endif
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= trace_record_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else begin
            fifo_level_o <= level_nxt;
            drop_count_o <= drop_nxt;
            if (trace_valid_i && !push) overflow_o <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (state == SEND && fire) idx <= pop ? '0 : idx + 1'b1;
            if (state == IDLE && fifo_level_o != '0) state <= FIRST;
            else if (pop) state <= level_nxt != '0 ? FIRST : IDLE;
`ifdef TRACE_DRAIN_HEADER_EN
            else if (state == HEADER && out_ready_i) state <= SEND;
`endif
        end
    end
endmodule

// File: tb/tb_trace_drain.sv
// tb_trace_drain: directed and random stimulus for trace_drain, checked against a queue-based packet model.
module tb_trace_drain;
    localparam int RW = 128;
    localparam int OW = 32;
    localparam int D  = 8;
    localparam int N  = RW / OW;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tv  = 1'b0;
    logic          rdy = 1'b0;
    logic [RW-1:0] rec = '0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic [15:0]   drop_count;
    int total = 0;
    int bad   = 0;
    logic [RW-1:0] q[$];
    int m_idx   = 0;
    bit m_send  = 0;
    int m_drops = 0;
    bit m_ovf   = 0;

    trace_drain #(.REC_WIDTH(RW), .OUT_WIDTH(OW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .trace_valid_i(tv), .trace_record_i(rec),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(rdy), .fifo_level_o(fifo_level), .overflow_o(overflow),
        .drop_count_o(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_idx   = 0;
        m_send  = 0;
        m_drops = 0;
        m_ovf   = 0;
    endtask

    function automatic logic [RW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic step(bit v, logic [RW-1:0] r, bit rd);
        bit fire, pop, acc, was_nonempty;
        tv = v;
        rec = r;
        rdy = rd;
        @(negedge clk);
        chk("valid", out_valid, m_send);
        if (m_send) begin
            chk("data", out_data, q[0][m_idx*OW +: OW]);
            chk("last", out_last, m_idx == N - 1);
        end
        chk("level", fifo_level, q.size());
        chk("overflow", overflow, m_ovf);
        chk("drops", drop_count, m_drops);
        fire = m_send && rd;
        pop = fire && m_idx == N - 1;
        acc = v && (q.size() < D || pop);
        was_nonempty = q.size() != 0;
        if (fire) m_idx++;
        if (pop) begin
            void'(q.pop_front());
            m_idx = 0;
        end
        if (acc) q.push_back(r);
        else if (v) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
        end
        m_send = m_send ? (pop ? q.size() != 0 : 1'b1) : was_nonempty;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drops", drop_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 128'h44444444_33333333_22222222_11111111, 1);
        repeat (6) step(0, '0, 1);
        chk("single_idle_valid", out_valid, 0);
        chk("single_idle_level", fifo_level, 0);
        step(1, rnd(), 1);
        repeat (3) step(0, '0, 1);
        repeat (5) step(0, '0, 0);
        repeat (5) step(0, '0, 1);
        for (int i = 0; i < 10; i++) step(1, rnd(), 0);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_drops", drop_count, 2);
        chk("ovf_flag", overflow, 1);
        repeat (40) step(0, '0, 1);
        for (int i = 0; i < 8; i++) step(1, rnd(), 0);
        repeat (3) step(0, '0, 1);
        step(1, rnd(), 1);
        chk("simul_level", fifo_level, 8);
        chk("simul_drops", drop_count, 2);
        repeat (40) step(0, '0, 1);
        step(1, rnd(), 1);
        repeat (3) step(0, '0, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_last", out_last, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_drops", drop_count, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, rnd(), 1);
        repeat (6) step(0, '0, 1);
        for (int i = 0; i < 400; i++) step($urandom_range(0, 9) < 4, rnd(), $urandom_range(0, 9) < 6);
        repeat (60) step(0, '0, 1);
        chk("final_level", fifo_level, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
